// File: rtl/taylor_cos_scheduler.sv
// Shares one Taylor-series cosine engine between N requesters.
// A round-robin arbiter picks one pending request and latches its angle. The FSM then runs the
// engine's start/ready handshake and returns the result to the winner with a one-hot response
// strobe. A wait timer aborts the job if the engine hangs.
//
// Ports:
//   clock, reset             system clock, asynchronous active-low reset
//   req_valid/req_angle      per-requester request and angle (requester i at [i*W +: W])
//   req_ready                one-hot acceptance pulse
//   resp_valid               one-hot response pulse; resp_data/resp_err belong to that requester
//   resp_data, resp_err      result (held until next response), timeout-abort flag
//   busy                     high from acceptance until the cycle after the response
//   timeout_err, clear_err   sticky timeout flag and its synchronous clear (clear wins)
//   eng_start/eng_angle      engine start level and registered angle
//   eng_ready/eng_result     engine ready level and result
module taylor_cos_scheduler #(
  parameter int unsigned W       = 24,
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_angle,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   resp_valid,
  output logic [W-1:0]   resp_data,
  output logic           resp_err,
  output logic           busy,
  output logic           timeout_err,
  input  logic           clear_err,
  output logic           eng_start,
  output logic [W-1:0]   eng_angle,
  input  logic           eng_ready,
  input  logic [W-1:0]   eng_result
);

  localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1;
  // One spare bit so the timer can reach TIMEOUT without wrapping.
  localparam int unsigned TmW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StStart,
    StWaitAck,
    StWaitDone,
    StResp,
    StGap,
    StAbort
  } state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] last_q, last_d;
  logic [IdW-1:0] id_q, id_d;
  logic [TmW-1:0] timer_q, timer_d;
  logic           busy_q, busy_d;
  logic           start_q, start_d;
  logic           terr_q, terr_d;
  logic [W-1:0]   angle_q, angle_d;
  logic [W-1:0]   data_q, data_d;

  logic [W-1:0]   angle_arr [N];
  logic           win_found;
  logic [IdW-1:0] win_id;
  int unsigned    rr_idx;
  logic           timer_expired;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      angle_arr[i] = req_angle[i*W +: W];
    end
  end

  // Search starts just after the last winner, so the previous winner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rr_idx    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      rr_idx = (32'(last_q) + k) % N;
      if (!win_found && req_valid[IdW'(rr_idx)]) begin
        win_found = 1'b1;
        win_id    = IdW'(rr_idx);
      end
    end
  end

  // >= rather than == so an ack landing on the last allowed cycle still times out in WAIT_DONE.
  assign timer_expired = (timer_q >= TmW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    timer_d   = timer_q;
    busy_d    = busy_q;
    start_d   = start_q;
    terr_d    = terr_q;
    angle_d   = angle_q;
    data_d    = data_q;
    req_ready = '0;

    unique case (state_q)
      StIdle: begin
        if (|req_valid) state_d = StGrant;
      end
      StGrant: begin
        // A request withdrawn between IDLE and GRANT leaves nothing to serve.
        if (win_found) begin
          req_ready[win_id] = 1'b1;
          angle_d           = angle_arr[win_id];
          id_d              = win_id;
          last_d            = win_id;
          busy_d            = 1'b1;
          state_d           = StStart;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: begin
        start_d = 1'b1;
        timer_d = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        timer_d = timer_q + 1'b1;
        // Ready is still high from the previous job until the engine takes this one.
        if (!eng_ready) begin
          state_d = StWaitDone;
        end else if (timer_expired) begin
          start_d = 1'b0;
          terr_d  = 1'b1;
          data_d  = '0;
          state_d = StAbort;
        end
      end
      StWaitDone: begin
        timer_d = timer_q + 1'b1;
        if (eng_ready) begin
          data_d  = eng_result;
          start_d = 1'b0;
          state_d = StResp;
        end else if (timer_expired) begin
          start_d = 1'b0;
          terr_d  = 1'b1;
          data_d  = '0;
          state_d = StAbort;
        end
      end
      StResp:  state_d = StGap;
      StAbort: state_d = StGap;
      StGap: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (clear_err) terr_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      last_q  <= IdW'(N - 1);
      id_q    <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      terr_q  <= 1'b0;
      angle_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      terr_q  <= terr_d;
      angle_q <= angle_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == StResp || state_q == StAbort) resp_valid[id_q] = 1'b1;
  end

  assign resp_err    = (state_q == StAbort);
  assign resp_data   = data_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign eng_start   = start_q;
  assign eng_angle   = angle_q;

endmodule

// File: tb/tb_taylor_cos_scheduler.sv
// Bench for taylor_cos_scheduler: behavioural engine stub, round-robin/scoreboard monitor,
// a vector table and hand sequences for rotation, timeout and mid-job reset.
module tb_taylor_cos_scheduler;
  localparam int W = 24;
  localparam int N = 4;
  localparam int TIMEOUT = 64;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_angle;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic           busy;
  logic           timeout_err;
  logic           clear_err;
  logic           eng_start;
  logic [W-1:0]   eng_angle;
  logic           eng_ready;
  logic [W-1:0]   eng_result;

  taylor_cos_scheduler #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_angle   (req_angle),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .busy        (busy),
    .timeout_err (timeout_err),
    .clear_err   (clear_err),
    .eng_start   (eng_start),
    .eng_angle   (eng_angle),
    .eng_ready   (eng_ready),
    .eng_result  (eng_result)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cosine of an unsigned Q1.23 angle, as a Q1.23 word (1.0 wraps to 0x800000).
  function automatic logic [W-1:0] ref_cos(input logic [W-1:0] a);
    real x;
    x = $cos(real'(a) / 8388608.0) * 8388608.0;
    return W'($rtoi(x));
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Engine stub: acks by dropping ready, later raises it with the result.
  logic eng_stuck = 1'b0;
  int   eng_lat_min = 1;
  int   eng_lat_max = 8;
  int   e_state;
  int   e_cnt;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      eng_ready  <= 1'b1;
      eng_result <= '0;
      e_state    <= 0;
      e_cnt      <= 0;
    end else begin
      case (e_state)
        0: if (eng_start && !eng_stuck) begin
             e_cnt   <= int'($urandom_range(0, 2));
             e_state <= 1;
           end
        1: if (e_cnt == 0) begin
             eng_ready <= 1'b0;
             e_cnt     <= int'($urandom_range(eng_lat_min, eng_lat_max));
             e_state   <= 2;
           end else e_cnt <= e_cnt - 1;
        2: if (e_cnt == 0) begin
             eng_ready  <= 1'b1;
             eng_result <= ref_cos(eng_angle);
             e_state    <= 3;
           end else e_cnt <= e_cnt - 1;
        3: if (!eng_start) e_state <= 0;
        default: e_state <= 0;
      endcase
    end
  end

  // Monitor: round-robin model on every grant, scoreboard on every response.
  typedef struct {
    int           id;
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  exp_t         sb[$];
  exp_t         m_e;
  int           m_last = N - 1;
  int           m_w;
  logic [N-1:0] m_mask;
  int           start_hi = 0;
  int           got_ids[$];
  logic [N-1:0] last_rv;
  logic [W-1:0] last_rd;
  logic         last_re;

  always @(negedge clock) begin
    if (!reset) begin
      sb.delete();
      m_last = N - 1;
    end else begin
      if (eng_start) start_hi++;
      if (req_ready != '0) begin
        m_w    = rr_pick(req_valid, m_last);
        m_mask = '0;
        if (m_w >= 0) m_mask[m_w] = 1'b1;
        chk("single_job", 64'(sb.size()), 0);
        chk("rr_grant", 64'(req_ready), 64'(m_mask));
        if (m_w >= 0) begin
          m_e.id   = m_w;
          m_e.err  = eng_stuck;
          m_e.data = eng_stuck ? '0 : ref_cos(req_angle[m_w*W +: W]);
          sb.push_back(m_e);
          m_last = m_w;
        end
      end
      if (resp_valid != '0) begin
        last_rv = resp_valid;
        last_rd = resp_data;
        last_re = resp_err;
        for (int i = 0; i < N; i++) if (resp_valid[i]) begin got_ids.push_back(i); break; end
        if (sb.size() == 0) begin
          chk("resp_unexpected", 64'(resp_valid), 0);
        end else begin
          m_e    = sb.pop_front();
          m_mask = '0;
          m_mask[m_e.id] = 1'b1;
          chk("resp_valid", 64'(resp_valid), 64'(m_mask));
          chk("resp_data", 64'(resp_data), 64'(m_e.data));
          chk("resp_err", 64'(resp_err), 64'(m_e.err));
        end
      end
    end
  end

  // Runs until n responses are seen; drops accepted requests when drop is set.
  task automatic collect(input int n, input bit drop, input int bound);
    int           got;
    logic [N-1:0] acc;
    bit           ok;
    got = 0;
    ok  = 0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clock);
      acc = req_ready;
      if (resp_valid != '0) got++;
      @(posedge clock); #1;
      if (drop) req_valid = req_valid & ~acc;
      if (got >= n) begin ok = 1; break; end
    end
    req_valid = '0;
    chk("collect_bound", 64'(ok), 1);
  endtask

  task automatic run_job(input int id, input logic [W-1:0] ang);
    req_angle[id*W +: W] = ang;
    req_valid[id]        = 1'b1;
    collect(1, 1, 200);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 0);
    chk({tag, "_resp_data"}, 64'(resp_data), 0);
    chk({tag, "_resp_err"}, 64'(resp_err), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_timeout_err"}, 64'(timeout_err), 0);
    chk({tag, "_eng_start"}, 64'(eng_start), 0);
    chk({tag, "_eng_angle"}, 64'(eng_angle), 0);
  endtask

  typedef struct {
    int           id;
    logic [W-1:0] angle;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t              tbl[6];
  int                rr_exp[5] = '{0, 1, 2, 3, 0};
  logic signed [W-1:0] sv;
  int                mag;
  bit                found;
  bit                acc1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    req_valid = '0;
    req_angle = '0;
    clear_err = 1'b0;

    tbl[0] = '{0, 24'h000000, 24'h800000};
    tbl[1] = '{1, 24'h200000, ref_cos(24'h200000)};
    tbl[2] = '{2, 24'h400000, ref_cos(24'h400000)};
    tbl[3] = '{3, 24'h800000, ref_cos(24'h800000)};
    tbl[4] = '{3, 24'hFFFFFF, ref_cos(24'hFFFFFF)};
    tbl[5] = '{2, 24'hC90FDB, ref_cos(24'hC90FDB)};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock); #1;
    reset = 1'b1;

    // Vector table, one requester per job
    for (int i = 0; i < 6; i++) begin
      m_mask = '0;
      m_mask[tbl[i].id] = 1'b1;
      run_job(tbl[i].id, tbl[i].angle);
      chk("vec_resp_valid", 64'(last_rv), 64'(m_mask));
      chk("vec_resp_data", 64'(last_rd), 64'(tbl[i].exp_data));
      chk("vec_resp_err", 64'(last_re), 0);
      if (i == 0) begin
        @(negedge clock);
        chk("busy_in_gap", 64'(busy), 1);
        @(negedge clock);
        chk("busy_after_gap", 64'(busy), 0);
        @(posedge clock); #1;
      end
    end
    // cos(pi/2) is near zero
    sv  = last_rd;
    mag = sv;
    if (mag < 0) mag = -mag;
    chk("pi2_small", 64'(mag <= 64), 1);

    // All four held valid from reset: strict rotation 0,1,2,3,0
    @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); #1; reset = 1'b1;
    for (int i = 0; i < N; i++) req_angle[i*W +: W] = W'(24'h100000 * (i + 1));
    got_ids.delete();
    req_valid = '1;
    collect(5, 0, 1000);
    chk("rr_count", 64'(got_ids.size()), 5);
    for (int k = 0; k < 5 && k < got_ids.size(); k++) chk("rr_order", 64'(got_ids[k]), 64'(rr_exp[k]));

    // After serving 1, pending 0 and 2: 2 goes first
    run_job(1, 24'h0A0000);
    req_angle[0*W +: W] = 24'h111111;
    req_angle[2*W +: W] = 24'h222222;
    got_ids.delete();
    req_valid = 4'b0101;
    collect(2, 1, 500);
    chk("rr_pend_count", 64'(got_ids.size()), 2);
    if (got_ids.size() == 2) begin
      chk("rr_pend_first", 64'(got_ids[0]), 2);
      chk("rr_pend_second", 64'(got_ids[1]), 0);
    end

    // Hung engine: timeout after TIMEOUT cycles of eng_start
    eng_stuck = 1'b1;
    start_hi  = 0;
    run_job(0, 24'h123456);
    chk("to_resp_valid", 64'(last_rv), 1);
    chk("to_resp_err", 64'(last_re), 1);
    chk("to_resp_data", 64'(last_rd), 0);
    chk("to_start_cycles", 64'(start_hi), 64'(TIMEOUT));
    repeat (3) @(posedge clock);
    #1;
    chk("to_sticky", 64'(timeout_err), 1);
    clear_err = 1'b1;
    @(posedge clock); #1;
    clear_err = 1'b0;
    chk("to_cleared", 64'(timeout_err), 0);
    eng_stuck = 1'b0;
    run_job(3, 24'h300000);
    chk("post_to_err", 64'(last_re), 0);
    chk("post_to_data", 64'(last_rd), 64'(ref_cos(24'h300000)));
    chk("post_to_flag", 64'(timeout_err), 0);

    // Reset while the engine is computing
    eng_lat_min = 30;
    eng_lat_max = 30;
    req_angle[1*W +: W] = 24'h050505;
    req_valid[1] = 1'b1;
    found = 0;
    acc1  = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (req_ready[1]) acc1 = 1;
      if (eng_start && !eng_ready) begin found = 1; break; end
      @(posedge clock); #1;
      if (acc1) req_valid[1] = 1'b0;
    end
    chk("t6_reached_wait", 64'(found), 1);
    req_valid = '0;
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    repeat (3) begin
      @(negedge clock);
      chk("midreset_no_resp", 64'(resp_valid), 0);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    eng_lat_min = 1;
    eng_lat_max = 8;
    repeat (5) begin
      @(negedge clock);
      chk("postreset_no_resp", 64'(resp_valid), 0);
    end
    @(posedge clock); #1;
    run_job(0, 24'h000000);
    chk("t1_again_valid", 64'(last_rv), 1);
    chk("t1_again_data", 64'(last_rd), 64'h800000);
    chk("t1_again_err", 64'(last_re), 0);

    // Randomised traffic checked by the monitor
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] acc;
      @(negedge clock);
      acc = req_ready;
      @(posedge clock); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 5) == 0) begin
          req_angle[i*W +: W] = W'($urandom);
          req_valid[i]        = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 40) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (sb.size() == 0 && !busy) break;
    end
    chk("drain_scoreboard", 64'(sb.size()), 0);
    chk("drain_busy", 64'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
